// File: rtl/uart_rx_param_if.sv
// Purpose: serial line in, received word plus status pulses out, for uart_rx_param.
// Latency: none, plain wires.
// Backpressure: none; the receiver side owns data/valid/frame_err/parity_err/busy.
interface uart_rx_param_if #(
    parameter int DATA_W = 8
);
    logic              get;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              frame_err;
    logic              parity_err;
    logic              busy;

    modport master (
        input  get,
        output data,
        output valid,
        output frame_err,
        output parity_err,
        output busy
    );

    modport slave (
        output get,
        input  data,
        input  valid,
        input  frame_err,
        input  parity_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// Purpose: UART receiver with mid-bit sampling, false-start and break rejection; parity via `UART_RX_PARITY_EN.
// Latency: valid/frame_err/parity_err one cycle after the stop-bit sample, together with busy falling.
// Backpressure: none; data is held until the next good frame, status outputs are single-cycle pulses.
module uart_rx_param #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BAUD    = 9600,
    parameter int DATA_W  = 8,
    parameter int PAR_ODD = 0
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_param_if.master rx
);
    localparam int BIT_CNT = CLK_HZ / BAUD;
    localparam int HALF    = BIT_CNT / 2;
    localparam int CW      = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
    localparam int IW      = $clog2(DATA_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CNT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    if (DATA_W < 5 || DATA_W > 9 || HALF < 1 || PAR_ODD < 0 || PAR_ODD > 1) begin : g_bad_cfg
        $error("uart_rx_param: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] shreg;
    logic              sync1;
    logic              sync2;
    logic              sync3;
    logic              settled;
    logic              armed;
    logic              line;
    logic              start_edge;
    logic              cnt_last;
    logic              cnt_mid;
    logic              par_ok;
    logic              sample_bit;
    logic              stop_sample;
    logic              valid_d;
    logic              ferr_d;
    logic              busy_d;

    // The chain is preset high, so the start detector only arms once the real line has
    // been seen idle; a reset in the middle of a frame then cannot fake a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            sync3   <= 1'b1;
            settled <= 1'b0;
            armed   <= 1'b0;
        end else begin
            sync1   <= rx.get;
            sync2   <= sync1;
            sync3   <= sync2;
            settled <= 1'b1;
            armed   <= armed | (settled & sync1 & sync2 & sync3);
        end
    end

    assign line       = sync2;
    assign start_edge = armed & sync3 & ~sync2;
    assign cnt_last   = (cnt == CNT_LAST);
    assign cnt_mid    = (cnt == CNT_MID);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt_mid) begin
                    if (line) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (sample_bit && idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_last) begin
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_last) begin
                    if (line) begin
                        state_n = IDLE;
                    end else begin
                        state_n = BREAK;
                    end
                end
            end
            BREAK: begin
                if (line) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sample_bit  = (state == DATA) && cnt_last;
        stop_sample = (state == STOP) && cnt_last;
        valid_d     = stop_sample && line && par_ok;
        ferr_d      = stop_sample && !line;
        busy_d      = (state_n != IDLE) && (state_n != BREAK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            rx.data      <= '0;
            rx.valid     <= 1'b0;
            rx.frame_err <= 1'b0;
            rx.busy      <= 1'b0;
        end else begin
            // Restarting on every state change also realigns DATA to the measured start-bit centre.
            if (state_n != state || cnt_last || state == IDLE || state == BREAK) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (state != DATA) begin
                idx <= '0;
            end else if (sample_bit) begin
                idx <= idx + IW'(1);
            end
            if (sample_bit) begin
                shreg[idx] <= line;
            end
            if (valid_d) begin
                rx.data <= shreg;
            end
            rx.valid     <= valid_d;
            rx.frame_err <= ferr_d;
            rx.busy      <= busy_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic perr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit       <= 1'b0;
            rx.parity_err <= 1'b0;
        end else begin
            if (state == PARITY && cnt_last) begin
                par_bit <= line;
            end
            rx.parity_err <= perr_d;
        end
    end

    assign par_ok = (par_bit == ((^shreg) ^ 1'(PAR_ODD)));
    assign perr_d = stop_sample && line && !par_ok;
`else
    assign par_ok        = 1'b1;
    assign rx.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: directed and random frames against a frame-level model of expected pulses and data.
module tb_uart_rx_param;
    localparam int CLK_HZ  = 1_000_000;
    localparam int BAUD    = 100_000;
    localparam int DATA_W  = 8;
    localparam int PAR_ODD = 0;
    localparam int BIT_CNT = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_param_if #(.DATA_W(DATA_W)) bus ();

    uart_rx_param #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .DATA_W (DATA_W),
        .PAR_ODD(PAR_ODD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx (bus)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int perr_cnt  = 0;
    int viol      = 0;
    int npulse    = 0;
    int exp_valid = 0;
    int exp_ferr  = 0;
    int exp_perr  = 0;
    logic [7:0] exp_data = 8'h00;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic pulse_prev = 1'b0;

    // Pulse monitor: counts pulses and records pulse-shape violations.
    always @(negedge clk) begin
        npulse = int'(bus.valid === 1'b1) + int'(bus.frame_err === 1'b1) + int'(bus.parity_err === 1'b1);
        if (bus.valid === 1'b1) begin
            valid_cnt++;
            rx_q.push_back(bus.data);
        end
        if (bus.frame_err === 1'b1) ferr_cnt++;
        if (bus.parity_err === 1'b1) perr_cnt++;
        if (npulse > 1) viol++;
        if (npulse > 0 && bus.busy !== 1'b0) viol++;
        if (npulse > 0 && pulse_prev) viol++;
        pulse_prev = (npulse > 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_counts(input string tag);
        chk({tag, ".valid_cnt"}, valid_cnt, exp_valid);
        chk({tag, ".ferr_cnt"}, ferr_cnt, exp_ferr);
        chk({tag, ".perr_cnt"}, perr_cnt, exp_perr);
        chk({tag, ".data"}, bus.data, exp_data);
        chk({tag, ".busy"}, bus.busy, 1'b0);
    endtask

    task automatic hold(input logic v, input int n);
        bus.get = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nb, input int rst_pos);
        for (int i = 0; i < nb; i++) begin
            if (i == rst_pos) begin
                hold(bits[i], BIT_CNT / 2);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_mid.data", bus.data, 0);
                chk("rst_mid.valid", bus.valid, 0);
                chk("rst_mid.frame_err", bus.frame_err, 0);
                chk("rst_mid.parity_err", bus.parity_err, 0);
                chk("rst_mid.busy", bus.busy, 0);
                exp_data = 8'h00;
                hold(bits[i], BIT_CNT - BIT_CNT / 2 - 1);
            end else begin
                hold(bits[i], BIT_CNT);
            end
            if (i == 3) chk("busy_mid_frame", bus.busy, 1);
        end
    endtask

    // Frame-level model: a low stop bit is a framing error, else a bad parity bit is a
    // parity error, else the byte is delivered; a reset inside the frame yields nothing.
    task automatic frame(input string tag, input logic [7:0] b, input logic stop,
                         input logic pflip, input int rst_pos);
        logic [10:0] bits;
        int nb;
        bits    = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = b[i];
        nb = 9;
        if (PAR_EN) begin
            bits[nb] = (^b) ^ 1'(PAR_ODD) ^ pflip;
            nb++;
        end
        bits[nb] = stop;
        nb++;
        send_bits(bits, nb, rst_pos);
        if (rst_pos < 0) begin
            if (!stop) begin
                exp_ferr++;
            end else if (PAR_EN && pflip) begin
                exp_perr++;
            end else begin
                exp_valid++;
                exp_data = b;
                exp_q.push_back(b);
            end
        end
        expect_counts(tag);
    endtask

    initial begin
        bus.get = 1'b1;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.data", bus.data, 0);
        chk("reset.valid", bus.valid, 0);
        chk("reset.frame_err", bus.frame_err, 0);
        chk("reset.parity_err", bus.parity_err, 0);
        chk("reset.busy", bus.busy, 0);
        rst = 1'b0;
        hold(1'b1, 8);

        frame("f35", 8'h35, 1'b1, 1'b0, -1);
        hold(1'b1, 10);

        hold(1'b0, 3);
        hold(1'b1, 30);
        expect_counts("glitch");

        frame("brk_a5", 8'hA5, 1'b0, 1'b0, -1);
        hold(1'b0, 40);
        expect_counts("brk_hold");
        hold(1'b1, 10);
        expect_counts("brk_release");

        frame("b2b_00", 8'h00, 1'b1, 1'b0, -1);
        frame("b2b_ff", 8'hFF, 1'b1, 1'b0, -1);
        hold(1'b1, 10);

        frame("rst_81", 8'h81, 1'b1, 1'b0, 4);
        hold(1'b1, 10);
        frame("after_rst_5a", 8'h5A, 1'b1, 1'b0, -1);
        hold(1'b1, 10);

`ifdef UART_RX_PARITY_EN
        frame("par_c3", 8'hC3, 1'b1, 1'b0, -1);
        hold(1'b1, 5);
        frame("par_bad_5a", 8'h5A, 1'b1, 1'b1, -1);
        hold(1'b1, 5);
        frame("par_good_5a", 8'h5A, 1'b1, 1'b0, -1);
        hold(1'b1, 5);
`endif

        for (int k = 0; k < 16; k++) begin
            logic [7:0] b;
            logic       stop;
            logic       pf;
            int         gap;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            pf   = PAR_EN && ($urandom_range(0, 3) == 0);
            gap  = int'($urandom_range(0, 12));
            frame("rnd", b, stop, pf, -1);
            if (!stop) begin
                hold(1'b0, int'($urandom_range(0, 20)));
                hold(1'b1, 3 + gap);
            end else begin
                hold(1'b1, gap);
            end
        end

        hold(1'b1, 20);
        expect_counts("final");
        chk("pulse_rules", viol, 0);
        chk("rx_q.size", rx_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
            chk("rx_q.data", rx_q[k], exp_q[k]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
